ov7670_capture_ctrl: RTL and testbench

//  Frame-level sequencer for the OV7670 pixel capture path, in the PCLK domain.

---
 rtl/ov7670_pkg.sv | 25 ++
 rtl/ov7670_sync_edge.sv | 37 +++
 rtl/ov7670_capture_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ov7670_capture_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture path.
//  - cap_state_e : frame sequencer states
//  - ERR_*       : bit positions inside the 4-bit frame_err status word
//  - *_DEF       : default frame geometry (640x480 RGB565) and counter width
package ov7670_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArm     = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } cap_state_e;

    localparam int unsigned ERR_W        = 4;
    localparam int unsigned ERR_LINE_LEN = 0;
    localparam int unsigned ERR_LINE_CNT = 1;
    localparam int unsigned ERR_OVERFLOW = 2;
    localparam int unsigned ERR_ABORTED  = 3;

    localparam int unsigned H_BYTES_DEF     = 1280;
    localparam int unsigned V_LINES_DEF     = 480;
    localparam int unsigned SKIP_FRAMES_DEF = 2;
    localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/ov7670_sync_edge.sv
// Registers the sensor VSYNC/HREF strobes and derives single-cycle edge pulses.
// Ports:
//  PCLK     in   pixel clock, rising edge
//  RESETn   in   synchronous active-low reset, clears the edge registers
//  VSYNC    in   sensor VSYNC (high = vertical blanking)
//  HREF     in   sensor HREF (high = valid line bytes)
//  vs_rise  out  VSYNC went 0 -> 1 (end of frame)
//  vs_fall  out  VSYNC went 1 -> 0 (start of frame)
//  hr_fall  out  HREF went 1 -> 0 (end of line)
module ov7670_sync_edge (
    input  logic PCLK,
    input  logic RESETn,
    input  logic VSYNC,
    input  logic HREF,
    output logic vs_rise,
    output logic vs_fall,
    output logic hr_fall
);

    logic vs_q;
    logic hr_q;

    always_ff @(posedge PCLK) begin
        if (!RESETn) begin
            vs_q <= 1'b0;
            hr_q <= 1'b0;
        end else begin
            vs_q <= VSYNC;
            hr_q <= HREF;
        end
    end

    assign vs_rise = VSYNC & ~vs_q;
    assign vs_fall = ~VSYNC & vs_q;
    assign hr_fall = ~HREF & hr_q;

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// Frame-level sequencer for the OV7670 capture path (PCLK domain).
// Arms on a host request, discards settling frames after sensor init, gates the
// byte reader through capture_en, checks frame geometry and reports per-frame status.
// Ports:
//  PCLK, RESETn   clock / synchronous active-low reset
//  init_done      SCCB init complete (level); a drop acts like an abort
//  VSYNC, HREF    sensor frame / line strobes
//  cap_start      1-cycle capture request (ignored while busy)
//  cap_cont       re-arm automatically after each frame
//  cap_abort      1-cycle stop request
//  fifo_afull     downstream FIFO almost full
//  capture_en     enables byte reader / FIFO writes
//  busy           sequencer not idle
//  frame_start    1-cycle pulse on the first cycle of a captured frame
//  frame_end      1-cycle pulse, frame status valid
//  frame_ok       status valid with frame_end, 1 = no error bits
//  frame_err      [0] line length, [1] line count, [2] overflow, [3] aborted
//  frame_cnt      good frames since reset (wraps)
//  line_cnt       lines in the current / last frame
module ov7670_capture_ctrl
    import ov7670_pkg::*;
#(
    parameter int unsigned H_BYTES     = H_BYTES_DEF,
    parameter int unsigned V_LINES     = V_LINES_DEF,
    parameter int unsigned SKIP_FRAMES = SKIP_FRAMES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             PCLK,
    input  logic             RESETn,
    input  logic             init_done,
    input  logic             VSYNC,
    input  logic             HREF,
    input  logic             cap_start,
    input  logic             cap_cont,
    input  logic             cap_abort,
    input  logic             fifo_afull,
    output logic             capture_en,
    output logic             busy,
    output logic             frame_start,
    output logic             frame_end,
    output logic             frame_ok,
    output logic [ERR_W-1:0] frame_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] line_cnt
);

    localparam logic [CNT_W-1:0] H_BYTES_C = CNT_W'(H_BYTES);
    localparam logic [CNT_W-1:0] V_LINES_C = CNT_W'(V_LINES);
    localparam logic [CNT_W-1:0] SKIP_C    = CNT_W'(SKIP_FRAMES);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic vs_rise;
    logic vs_fall;
    logic hr_fall;

    ov7670_sync_edge u_sync_edge (
        .PCLK    (PCLK),
        .RESETn  (RESETn),
        .VSYNC   (VSYNC),
        .HREF    (HREF),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .hr_fall (hr_fall)
    );

    cap_state_e       state_q;
    logic [CNT_W-1:0] skip_cnt_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [CNT_W-1:0] line_cnt_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [ERR_W-1:0] err_q;
    logic             capture_en_q;
    logic             frame_start_q;
    logic             frame_end_q;
    logic             frame_ok_q;

    // init_done can only be low in ARM/CAPTURE after having fallen, so the level
    // is enough to detect the fall there.
    logic stop_req;
    assign stop_req = cap_abort | ~init_done;

    // Next values of the in-frame counters and error flags while in CAPTURE.
    logic [CNT_W-1:0] byte_nxt;
    logic [CNT_W-1:0] line_nxt;
    logic [ERR_W-1:0] err_nxt;

    always_comb begin
        byte_nxt = byte_cnt_q;
        line_nxt = line_cnt_q;
        err_nxt  = err_q;
        if (HREF && (byte_cnt_q != '1)) begin
            byte_nxt = byte_cnt_q + ONE_C;
        end
        if (hr_fall) begin
            line_nxt = line_cnt_q + ONE_C;
            byte_nxt = '0;
            if (byte_cnt_q != H_BYTES_C) begin
                err_nxt[ERR_LINE_LEN] = 1'b1;
            end
        end
        // Abort masks overflow and line-count checks raised in the same cycle.
        if (stop_req) begin
            err_nxt[ERR_ABORTED] = 1'b1;
        end else begin
            if (fifo_afull) begin
                err_nxt[ERR_OVERFLOW] = 1'b1;
            end
            // line_nxt already includes an hr_fall coincident with vs_rise.
            if (vs_rise && (line_nxt != V_LINES_C)) begin
                err_nxt[ERR_LINE_CNT] = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!RESETn) begin
            state_q       <= StIdle;
            skip_cnt_q    <= SKIP_C;
            byte_cnt_q    <= '0;
            line_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            err_q         <= '0;
            capture_en_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_ok_q    <= 1'b0;
        end else begin
            if (!init_done) begin
                skip_cnt_q <= SKIP_C;
            end else if (vs_rise && (skip_cnt_q != '0)) begin
                skip_cnt_q <= skip_cnt_q - ONE_C;
            end

            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (cap_start && init_done && !cap_abort) begin
                        state_q <= StArm;
                    end
                end
                StArm: begin
                    if (stop_req) begin
                        state_q <= StIdle;
                    end else if (vs_fall && (skip_cnt_q == '0) && !fifo_afull) begin
                        state_q       <= StCapture;
                        capture_en_q  <= 1'b1;
                        frame_start_q <= 1'b1;
                        byte_cnt_q    <= '0;
                        line_cnt_q    <= '0;
                        err_q         <= '0;
                    end
                end
                StCapture: begin
                    byte_cnt_q <= byte_nxt;
                    line_cnt_q <= line_nxt;
                    err_q      <= err_nxt;
                    if (stop_req || vs_rise) begin
                        state_q      <= StDone;
                        capture_en_q <= 1'b0;
                        frame_end_q  <= 1'b1;
                        frame_ok_q   <= (err_nxt == '0);
                        if (err_nxt == '0) begin
                            frame_cnt_q <= frame_cnt_q + ONE_C;
                        end
                    end else if (fifo_afull) begin
                        // Stays off for the rest of the frame.
                        capture_en_q <= 1'b0;
                    end
                end
                StDone: begin
                    if (cap_cont && !err_q[ERR_ABORTED]) begin
                        state_q <= StArm;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign capture_en  = capture_en_q;
    assign busy        = (state_q != StIdle);
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_ok    = frame_ok_q;
    assign frame_err   = err_q;
    assign frame_cnt   = frame_cnt_q;
    assign line_cnt    = line_cnt_q;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Self-checking bench for ov7670_capture_ctrl with a small geometry (8 bytes x 4 lines,
// one skipped frame). A frame-level reference model predicts, per frame, whether it is
// captured and what status it reports; observed frame_end pulses are queued and compared.
module tb_ov7670_capture_ctrl;

    localparam int unsigned H    = 8;
    localparam int unsigned V    = 4;
    localparam int unsigned SKIP = 1;
    localparam int unsigned CW   = 16;

    logic          PCLK;
    logic          RESETn;
    logic          init_done;
    logic          VSYNC;
    logic          HREF;
    logic          cap_start;
    logic          cap_cont;
    logic          cap_abort;
    logic          fifo_afull;
    logic          capture_en;
    logic          busy;
    logic          frame_start;
    logic          frame_end;
    logic          frame_ok;
    logic [3:0]    frame_err;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] line_cnt;

    ov7670_capture_ctrl #(
        .H_BYTES     (H),
        .V_LINES     (V),
        .SKIP_FRAMES (SKIP),
        .CNT_W       (CW)
    ) u_dut (
        .PCLK        (PCLK),
        .RESETn      (RESETn),
        .init_done   (init_done),
        .VSYNC       (VSYNC),
        .HREF        (HREF),
        .cap_start   (cap_start),
        .cap_cont    (cap_cont),
        .cap_abort   (cap_abort),
        .fifo_afull  (fifo_afull),
        .capture_en  (capture_en),
        .busy        (busy),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt),
        .line_cnt    (line_cnt)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [3:0]    err;
        logic          ok;
        logic [CW-1:0] cnt;
        logic [CW-1:0] lines;
    } stat_t;

    stat_t got_q[$];
    int    n_start;
    int    n_cmp;
    int    n_bad;

    // Reference model state: armed = waiting in ARM, skip = frames still to discard.
    bit          m_armed;
    int          m_skip;
    bit          m_prev_vs;
    logic [CW-1:0] m_good;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One PCLK cycle: apply strobes, update model with what the DUT sampled, then
    // sample outputs 1 time unit after the edge.
    task automatic drive(input logic vs, input logic hr);
        VSYNC = vs;
        HREF  = hr;
        @(posedge PCLK);
        if (!RESETn) begin
            m_skip    = SKIP;
            m_prev_vs = 1'b0;
            m_armed   = 1'b0;
            m_good    = '0;
        end else begin
            if (!init_done) m_skip = SKIP;
            else if (vs && !m_prev_vs && m_skip > 0) m_skip--;
            m_prev_vs = vs;
        end
        #1;
        if (frame_end) got_q.push_back({frame_err, frame_ok, frame_cnt, line_cnt});
        if (frame_start) n_start++;
    endtask

    task automatic start_req();
        cap_start = 1'b1;
        drive(1'b1, 1'b0);
        cap_start = 1'b0;
        if (init_done) m_armed = 1'b1;
        drive(1'b1, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cap_en"}, 32'(capture_en), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_fstart"}, 32'(frame_start), 32'd0);
        check_eq({tag, "_fend"}, 32'(frame_end), 32'd0);
        check_eq({tag, "_fok"}, 32'(frame_ok), 32'd0);
        check_eq({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check_eq({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
        check_eq({tag, "_lcnt"}, 32'(line_cnt), 32'd0);
    endtask

    // One full frame followed by blanking. odd_line gets odd_len bytes instead of H;
    // afull_line / abort_line inject a 1-cycle pulse inside that line (-1 = none).
    task automatic run_frame(input int nlines, input int odd_line, input int odd_len,
                             input int afull_line, input int abort_line, input bit cont);
        bit         cap;
        bit         aborted;
        bit         ok;
        logic [3:0] e;
        int         done_lines;
        int         nb;
        stat_t      s;
        cap_cont   = cont;
        cap        = m_armed && (m_skip == 0);
        e          = '0;
        done_lines = 0;
        aborted    = 1'b0;
        drive(1'b0, 1'b0);
        check_eq("cap_en_latency", 32'(capture_en), 32'(cap));
        for (int l = 0; l < nlines && !aborted; l++) begin
            repeat ($urandom_range(1, 2)) drive(1'b0, 1'b0);
            nb = (l == odd_line) ? odd_len : H;
            for (int b = 0; b < nb; b++) begin
                fifo_afull = (l == afull_line) && (b == 2);
                cap_abort  = (l == abort_line) && (b == 4);
                drive(1'b0, 1'b1);
                if (fifo_afull && cap) begin
                    e[2] = 1'b1;
                    check_eq("afull_cap_en", 32'(capture_en), 32'd0);
                end
                if (cap_abort) begin
                    if (cap) begin
                        e[3]    = 1'b1;
                        aborted = 1'b1;
                        check_eq("abort_cap_en", 32'(capture_en), 32'd0);
                    end
                    m_armed = 1'b0;
                end
                fifo_afull = 1'b0;
                cap_abort  = 1'b0;
                if (aborted) break;
            end
            if (!aborted) begin
                if (nb != H) e[0] = 1'b1;
                done_lines++;
            end
        end
        // Zero tail gap makes the last line end on the same edge as vs_rise.
        if (aborted || $urandom_range(0, 1) == 1) drive(1'b0, 1'b0);
        if (cap && !aborted && done_lines != V) e[1] = 1'b1;
        repeat ($urandom_range(3, 5)) drive(1'b1, 1'b0);

        if (cap) begin
            ok = (e == 4'd0);
            if (ok) m_good = m_good + 1'b1;
            check_eq("n_frame_end", 32'(got_q.size()), 32'd1);
            if (got_q.size() > 0) begin
                s = got_q.pop_front();
                check_eq("frame_err", 32'(s.err), 32'(e));
                check_eq("frame_ok", 32'(s.ok), 32'(ok));
                check_eq("frame_cnt", 32'(s.cnt), 32'(m_good));
                check_eq("line_cnt", 32'(s.lines), 32'(done_lines));
            end
            check_eq("frame_err_hold", 32'(frame_err), 32'(e));
            m_armed = cont && !aborted;
        end else begin
            check_eq("n_frame_end", 32'(got_q.size()), 32'd0);
        end
        got_q.delete();
        check_eq("n_frame_start", 32'(n_start), 32'(cap));
        n_start = 0;
        check_eq("busy", 32'(busy), 32'(m_armed));
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end

    int nl, odd_l, odd_n, af, ab;
    bit pre_cap;

    initial begin
        n_cmp = 0; n_bad = 0; n_start = 0;
        m_armed = 1'b0; m_skip = SKIP; m_prev_vs = 1'b0; m_good = '0;
        RESETn = 1'b0; init_done = 1'b0; VSYNC = 1'b1; HREF = 1'b0;
        cap_start = 1'b0; cap_cont = 1'b0; cap_abort = 1'b0; fifo_afull = 1'b0;
        repeat (3) drive(1'b1, 1'b0);
        check_all_zero("reset");
        RESETn = 1'b1;
        drive(1'b1, 1'b0);
        init_done = 1'b1;
        drive(1'b1, 1'b0);

        // 1: single capture; first frame after init is discarded.
        start_req();
        run_frame(V, -1, H, -1, -1, 1'b0);
        run_frame(V, -1, H, -1, -1, 1'b0);
        check_eq("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check_eq("t1_idle", 32'(busy), 32'd0);

        // 2: continuous mode, three good frames.
        cap_cont = 1'b1;
        start_req();
        repeat (3) run_frame(V, -1, H, -1, -1, 1'b1);
        check_eq("t2_frame_cnt", 32'(frame_cnt), 32'd4);

        // 3: short line, then too many lines.
        run_frame(V, 1, H - 1, -1, -1, 1'b1);
        run_frame(V + 1, -1, H, -1, -1, 1'b1);
        check_eq("t3_frame_cnt", 32'(frame_cnt), 32'd4);

        // 4: FIFO back-pressure in line 2.
        run_frame(V, -1, H, 1, -1, 1'b1);

        // 5: abort mid capture, then init_done drop while armed.
        run_frame(V, -1, H, -1, 1, 1'b1);
        check_eq("t5_idle_after_abort", 32'(busy), 32'd0);
        cap_cont = 1'b0;
        start_req();
        check_eq("t5_armed", 32'(busy), 32'd1);
        init_done = 1'b0;
        drive(1'b1, 1'b0);
        m_armed = 1'b0;
        drive(1'b1, 1'b0);
        check_eq("t5_init_drop_idle", 32'(busy), 32'd0);
        init_done = 1'b1;
        drive(1'b1, 1'b0);
        run_frame(V, -1, H, -1, -1, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                init_done = 1'b0;
                drive(1'b1, 1'b0);
                m_armed = 1'b0;
                drive(1'b1, 1'b0);
                init_done = 1'b1;
                drive(1'b1, 1'b0);
            end
            if ($urandom_range(0, 1) == 1) start_req();
            case ($urandom_range(0, 5))
                0:       nl = V - 1;
                1:       nl = V + 1;
                default: nl = V;
            endcase
            odd_l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            odd_n = ($urandom_range(0, 1) == 1) ? H - 1 : H + 1;
            af    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            ab    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
            run_frame(nl, odd_l, odd_n, af, ab, 1'($urandom_range(0, 1)));
        end

        // 6: reset in the middle of a captured frame.
        start_req();
        run_frame(V, -1, H, -1, -1, 1'b1);
        run_frame(V, -1, H, -1, -1, 1'b1);
        pre_cap = m_armed && (m_skip == 0);
        drive(1'b0, 1'b0);
        check_eq("t6_capturing", 32'(capture_en), 32'(pre_cap));
        repeat (3) drive(1'b0, 1'b1);
        RESETn = 1'b0;
        drive(1'b0, 1'b1);
        check_all_zero("t6_reset");
        RESETn   = 1'b1;
        cap_cont = 1'b0;
        repeat (2) drive(1'b0, 1'b0);
        repeat (4) drive(1'b1, 1'b0);
        got_q.delete();
        n_start = 0;
        run_frame(V, -1, H, -1, -1, 1'b0);
        run_frame(V, -1, H, -1, -1, 1'b0);
        check_eq("t6_no_restart_cnt", 32'(frame_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
